// File: rtl/t_inst_pkg.sv
// Shared constants and helpers for the t_inst elastic pipeline and its benches.
package t_inst_pkg;

   localparam int TB_WIDTH = 40;
   localparam int TB_DEPTH = 3;

   // Elaboration-time ceil(log2(n)), minimum 0; bounded loop keeps it synthesizable.
   function automatic int clog2(input int n);
      int r;
      r = 0;
      for (int i = 0; i < 31; i++) begin
         if ((1 << i) < n) r = i + 1;
      end
      return r;
   endfunction

endpackage

// File: rtl/t_inst_pipe_stage.sv
// One register slot of the elastic pipeline: loads its source whenever it is ready, else holds.
// Zero added latency beyond the register; stalls are decided upstream via rdy.
module t_inst_pipe_stage #(
   parameter int WIDTH = 40
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             flush,
   input  logic             src_valid,
   input  logic [WIDTH-1:0] src_data,
   input  logic             rdy,
   output logic             v,
   output logic [WIDTH-1:0] d
);

   // Data loads even for invalid sources; only v qualifies it. Flush leaves d untouched.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         v <= 1'b0;
         d <= '0;
      end else if (flush) begin
         v <= 1'b0;
      end else if (rdy) begin
         v <= src_valid;
         d <= src_data;
      end
   end

endmodule

// File: rtl/t_inst_pipe.sv
// DEPTH-stage valid/ready delay pipeline with bubble collapse, flush and occupancy count.
// Latency DEPTH cycles from accept to out_valid; full pipe still streams 1/cycle when out_ready=1.
module t_inst_pipe
   import t_inst_pkg::*;
#(
   parameter int WIDTH = 40,
   parameter int DEPTH = 3,
   parameter int CNT_W = clog2(DEPTH + 1)
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             flush,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] in_data,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] out_data,
   output logic [CNT_W-1:0] occupancy
);

   logic [DEPTH-1:0] v;
   logic [DEPTH-1:0] rdy;
   logic [DEPTH-1:0] src_v;
   logic [WIDTH-1:0] d     [DEPTH];
   logic [WIDTH-1:0] src_d [DEPTH];
   logic             accept;
   logic             emit;

   genvar i;
   generate
      for (i = 0; i < DEPTH; i++) begin : g_stage
         // Unrolled ready chain: a stage can move if the sink is ready or any slot at/after it is empty.
         assign rdy[i] = out_ready | ~(&v[DEPTH-1:i]);

         if (i == 0) begin : g_head
            assign src_v[i] = accept;
            assign src_d[i] = in_data;
         end else begin : g_body
            assign src_v[i] = v[i-1];
            assign src_d[i] = d[i-1];
         end

         t_inst_pipe_stage #(.WIDTH(WIDTH)) u_stage (
            .clk       (clk),
            .rst_n     (rst_n),
            .flush     (flush),
            .src_valid (src_v[i]),
            .src_data  (src_d[i]),
            .rdy       (rdy[i]),
            .v         (v[i]),
            .d         (d[i])
         );
      end
   endgenerate

   assign in_ready  = rdy[0] & ~flush;
   assign accept    = in_valid & in_ready;
   assign out_valid = v[DEPTH-1];
   assign out_data  = d[DEPTH-1];
   assign emit      = out_valid & out_ready;

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         occupancy <= '0;
      end else if (flush) begin
         occupancy <= '0;
      end else begin
         occupancy <= occupancy + CNT_W'(accept) - CNT_W'(emit);
      end
   end

endmodule
